// File: rtl/linear_pkg.sv
// Constants and slot type shared by the linear-function stage and its result reorder buffer.
package linear_pkg;

    localparam int LIN_DW    = 16;
    localparam int LIN_IDW   = 4;
    localparam int LIN_DEPTH = 16;

    typedef struct packed {
        logic              valid;
        logic [LIN_DW-1:0] data;
    } lin_slot_t;

endpackage

// File: rtl/reorder_timer.sv
// Head-wait counter: counts cycles the head slot is empty while entries are buffered.
// Pulses expire_o on the cycle the count reaches TIMEOUT, then restarts from zero.
module reorder_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic count_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        expire_o = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            if (cnt_q == CW'(TIMEOUT - 1)) begin
                cnt_d    = '0;
                expire_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/linear_result_reorder.sv
// Tag-indexed reorder buffer releasing linear-function results strictly in tag order.
// Define REORDER_TIMEOUT_EN to let a stalled head be skipped after TIMEOUT cycles.
module linear_result_reorder
    import linear_pkg::*;
#(
    parameter int DW      = LIN_DW,
    parameter int IDW     = LIN_IDW,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           sysrst,
    input  logic           rvalid,
    input  logic [DW-1:0]  y,
    input  logic [IDW-1:0] oid,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic [DW-1:0]  dout_data,
    output logic [IDW-1:0] dout_id,
    output logic [IDW:0]   occupancy,
    output logic           err_overflow,
    output logic           err_skip
);

    localparam int DEPTH = 2**IDW;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DW-1:0]    data_q [DEPTH];
    logic [IDW-1:0]   head_q, head_d;
    logic [IDW:0]     occ_q, occ_d;
    logic             dvalid_q, dvalid_d;
    logic [DW-1:0]    ddata_q, ddata_d;
    logic [IDW-1:0]   did_q, did_d;
    logic             ovf_q, ovf_d;
    logic             wr, ld, skip;

    // A write to an occupied slot is dropped; the head slot is never bypassed to the output.
    assign wr = rvalid && !valid_q[oid];
    assign ld = valid_q[head_q] && (!dvalid_q || dout_ready);

    always_comb begin
        valid_d = valid_q;
        if (ld) valid_d[head_q] = 1'b0;
        if (wr) valid_d[oid]    = 1'b1;

        head_d = head_q;
        if (ld || skip) head_d = head_q + 1'b1;

        occ_d = occ_q + (IDW+1)'(wr) - (IDW+1)'(ld);
        ovf_d = ovf_q | (rvalid && valid_q[oid]);

        dvalid_d = dvalid_q;
        ddata_d  = ddata_q;
        did_d    = did_q;
        if (ld) begin
            dvalid_d = 1'b1;
            ddata_d  = data_q[head_q];
            did_d    = head_q;
        end else if (dvalid_q && dout_ready) begin
            dvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge sysrst) begin
        if (sysrst) begin
            valid_q  <= '0;
            head_q   <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
            dvalid_q <= 1'b0;
            ddata_q  <= '0;
            did_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            head_q   <= head_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
            dvalid_q <= dvalid_d;
            ddata_q  <= ddata_d;
            did_q    <= did_d;
        end
    end

    // Payload needs no reset: it is only read when the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (wr) data_q[oid] <= y;
    end

`ifdef REORDER_TIMEOUT_EN
    logic expire;
    logic skip_q;

    reorder_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (sysrst),
        .count_i  (!valid_q[head_q] && (occ_q != '0)),
        .clear_i  (ld || (occ_q == '0)),
        .expire_o (expire)
    );

    // If the awaited head result lands on the expiry edge, keep it rather than skip it.
    assign skip = expire && !(wr && (oid == head_q));

    always_ff @(posedge clk or posedge sysrst) begin
        if (sysrst)    skip_q <= 1'b0;
        else if (skip) skip_q <= 1'b1;
    end

    assign err_skip = skip_q;
`else
    assign skip     = 1'b0;
    assign err_skip = 1'b0;
`endif

    assign dout_valid   = dvalid_q;
    assign dout_data    = ddata_q;
    assign dout_id      = did_q;
    assign occupancy    = occ_q;
    assign err_overflow = ovf_q;

endmodule

// File: tb/tb_linear_result_reorder.sv
// Directed bench for linear_result_reorder; the timeout scenario follows REORDER_TIMEOUT_EN.
module tb_linear_result_reorder;

    localparam int DW  = 16;
    localparam int IDW = 4;

    logic           clk = 1'b0;
    logic           sysrst = 1'b0;
    logic           rvalid = 1'b0;
    logic [DW-1:0]  y = '0;
    logic [IDW-1:0] oid = '0;
    logic           dout_valid;
    logic           dout_ready = 1'b0;
    logic [DW-1:0]  dout_data;
    logic [IDW-1:0] dout_id;
    logic [IDW:0]   occupancy;
    logic           err_overflow;
    logic           err_skip;

    int vec  = 0;
    int miss = 0;

    logic [IDW-1:0] got_id[$];
    logic [DW-1:0]  got_data[$];

    linear_result_reorder #(.DW(DW), .IDW(IDW), .TIMEOUT(64)) dut (
        .clk          (clk),
        .sysrst       (sysrst),
        .rvalid       (rvalid),
        .y            (y),
        .oid          (oid),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_data    (dout_data),
        .dout_id      (dout_id),
        .occupancy    (occupancy),
        .err_overflow (err_overflow),
        .err_skip     (err_skip)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rvalid     = 1'b0;
        dout_ready = 1'b0;
        sysrst     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sysrst = 1'b0;
        got_id.delete();
        got_data.delete();
    endtask

    task automatic collect();
        if (dout_valid && dout_ready) begin
            got_id.push_back(dout_id);
            got_data.push_back(dout_data);
        end
    endtask

    task automatic test_reset();
        rvalid = 1'b1;
        oid    = 4'd0;
        y      = 16'hFFFF;
        sysrst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vec++;
        if ({dout_valid, dout_data, dout_id, occupancy, err_overflow, err_skip} !== '0) begin
            miss++;
            $display("FAIL reset_outputs: got v=%b d=%h id=%h occ=%0d ovf=%b skip=%b required all 0",
                     dout_valid, dout_data, dout_id, occupancy, err_overflow, err_skip);
        end
        rvalid = 1'b0;
        sysrst = 1'b0;
    endtask

    task automatic test_in_order();
        logic exp_v;
        do_reset();
        dout_ready = 1'b1;
        for (int t = 0; t <= 10; t++) begin
            @(negedge clk);
            exp_v = (t >= 2 && t <= 9);
            vec++;
            if (dout_valid !== exp_v) begin
                miss++;
                $display("FAIL inorder_valid t=%0d: got %b required %b", t, dout_valid, exp_v);
            end
            if (exp_v) begin
                vec++;
                if (dout_id !== 4'(t - 2) || dout_data !== 16'(16'h0036 + t - 2)) begin
                    miss++;
                    $display("FAIL inorder_data t=%0d: got id=%0d data=%h required id=%0d data=%h",
                             t, dout_id, dout_data, t - 2, 16'(16'h0036 + t - 2));
                end
            end
            if (t < 8) begin
                rvalid = 1'b1;
                oid    = 4'(t);
                y      = 16'(16'h0036 + t);
            end else begin
                rvalid = 1'b0;
            end
        end
        rvalid = 1'b0;
    endtask

    task automatic test_out_of_order();
        logic [IDW-1:0] tags [3] = '{4'd2, 4'd0, 4'd1};
        int             occ_max = 0;
        do_reset();
        dout_ready = 1'b1;
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            collect();
            if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
            if (t < 3) begin
                rvalid = 1'b1;
                oid    = tags[t];
                y      = {12'h00A, tags[t]};
            end else begin
                rvalid = 1'b0;
            end
        end
        vec++;
        if (occ_max != 2) begin
            miss++;
            $display("FAIL ooo_occ_peak: got %0d required 2", occ_max);
        end
        vec++;
        if (got_id.size() != 3) begin
            miss++;
            $display("FAIL ooo_count: got %0d required 3", got_id.size());
        end
        for (int i = 0; i < got_id.size() && i < 3; i++) begin
            vec++;
            if (got_id[i] !== 4'(i) || got_data[i] !== 16'(16'h00A0 + i)) begin
                miss++;
                $display("FAIL ooo_order[%0d]: got id=%0d data=%h required id=%0d data=%h",
                         i, got_id[i], got_data[i], i, 16'(16'h00A0 + i));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            dout_ready = (t >= 7);
            if (t >= 2 && t <= 6) begin
                vec++;
                if (dout_valid !== 1'b1 || dout_id !== 4'd0 || dout_data !== 16'h00B0) begin
                    miss++;
                    $display("FAIL bp_hold t=%0d: got v=%b id=%0d data=%h required v=1 id=0 data=00b0",
                             t, dout_valid, dout_id, dout_data);
                end
            end
            if (t == 6) begin
                vec++;
                if (occupancy !== 5'd3) begin
                    miss++;
                    $display("FAIL bp_occ: got %0d required 3", occupancy);
                end
            end
            collect();
            if (t < 4) begin
                rvalid = 1'b1;
                oid    = 4'(t);
                y      = 16'(16'h00B0 + t);
            end else begin
                rvalid = 1'b0;
            end
        end
        vec++;
        if (got_id.size() != 4) begin
            miss++;
            $display("FAIL bp_count: got %0d required 4", got_id.size());
        end
        for (int i = 0; i < got_id.size() && i < 4; i++) begin
            vec++;
            if (got_id[i] !== 4'(i) || got_data[i] !== 16'(16'h00B0 + i)) begin
                miss++;
                $display("FAIL bp_order[%0d]: got id=%0d data=%h required id=%0d data=%h",
                         i, got_id[i], got_data[i], i, 16'(16'h00B0 + i));
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        dout_ready = 1'b1;
        for (int t = 0; t < 13; t++) begin
            @(negedge clk);
            collect();
            if (t == 1) begin
                vec++;
                if (err_overflow !== 1'b0) begin
                    miss++;
                    $display("FAIL ovf_early: got %b required 0", err_overflow);
                end
            end
            if (t == 2) begin
                vec++;
                if (err_overflow !== 1'b1 || occupancy !== 5'd1) begin
                    miss++;
                    $display("FAIL ovf_set: got ovf=%b occ=%0d required ovf=1 occ=1",
                             err_overflow, occupancy);
                end
            end
            rvalid = 1'b0;
            if (t == 0) begin rvalid = 1'b1; oid = 4'd5; y = 16'h1111; end
            if (t == 1) begin rvalid = 1'b1; oid = 4'd5; y = 16'h2222; end
            if (t >= 2 && t <= 6) begin
                rvalid = 1'b1;
                oid    = 4'(t - 2);
                y      = 16'(16'h0C00 + t - 2);
            end
        end
        vec++;
        if (got_id.size() != 6) begin
            miss++;
            $display("FAIL ovf_count: got %0d required 6", got_id.size());
        end
        if (got_id.size() == 6) begin
            vec++;
            if (got_id[5] !== 4'd5 || got_data[5] !== 16'h1111) begin
                miss++;
                $display("FAIL ovf_slot5: got id=%0d data=%h required id=5 data=1111",
                         got_id[5], got_data[5]);
            end
        end
        vec++;
        if (err_overflow !== 1'b1 || occupancy !== 5'd0) begin
            miss++;
            $display("FAIL ovf_sticky: got ovf=%b occ=%0d required ovf=1 occ=0", err_overflow, occupancy);
        end
    endtask

    task automatic test_wrap_reset();
        int bad;
        do_reset();
        dout_ready = 1'b1;
        for (int t = 0; t < 26; t++) begin
            @(negedge clk);
            collect();
            if (t < 20) begin
                rvalid = 1'b1;
                oid    = 4'(t % 16);
                y      = 16'(16'h0D00 + t);
            end else begin
                rvalid = 1'b0;
            end
        end
        vec++;
        if (got_id.size() != 20) begin
            miss++;
            $display("FAIL wrap_count: got %0d required 20", got_id.size());
        end
        bad = 0;
        for (int i = 0; i < got_id.size() && i < 20; i++) begin
            if (got_id[i] !== 4'(i % 16) || got_data[i] !== 16'(16'h0D00 + i)) bad++;
        end
        vec++;
        if (bad != 0) begin
            miss++;
            $display("FAIL wrap_order: got %0d misordered outputs required 0", bad);
        end
        // Head is now 4: tag 6 stays buffered, tag 4 stalls in the output register.
        dout_ready = 1'b0;
        @(negedge clk); rvalid = 1'b1; oid = 4'd6; y = 16'h0E06;
        @(negedge clk); rvalid = 1'b1; oid = 4'd4; y = 16'h0E04;
        @(negedge clk); rvalid = 1'b0;
        @(negedge clk);
        vec++;
        if (dout_valid !== 1'b1 || dout_id !== 4'd4 || occupancy !== 5'd1) begin
            miss++;
            $display("FAIL pre_reset: got v=%b id=%0d occ=%0d required v=1 id=4 occ=1",
                     dout_valid, dout_id, occupancy);
        end
        sysrst = 1'b1;
        #1;
        vec++;
        if ({dout_valid, dout_data, dout_id, occupancy} !== '0) begin
            miss++;
            $display("FAIL mid_reset: got v=%b d=%h id=%0d occ=%0d required all 0",
                     dout_valid, dout_data, dout_id, occupancy);
        end
        @(negedge clk);
        @(negedge clk);
        sysrst     = 1'b0;
        dout_ready = 1'b1;
        bad = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (dout_valid !== 1'b0 || occupancy !== 5'd0) bad++;
        end
        vec++;
        if (bad != 0) begin
            miss++;
            $display("FAIL post_reset_quiet: got %0d active cycles required 0", bad);
        end
    endtask

    task automatic test_timeout();
        int skip_t = -1;
        do_reset();
        dout_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            collect();
            if (skip_t < 0 && err_skip === 1'b1) skip_t = t;
            rvalid = 1'b0;
            if (t == 0) begin rvalid = 1'b1; oid = 4'd1; y = 16'h00E1; end
            if (t == 1) begin rvalid = 1'b1; oid = 4'd2; y = 16'h00E2; end
        end
`ifdef REORDER_TIMEOUT_EN
        vec++;
        if (skip_t != 65) begin
            miss++;
            $display("FAIL timeout_skip_time: got cycle %0d required 65", skip_t);
        end
        vec++;
        if (got_id.size() != 2) begin
            miss++;
            $display("FAIL timeout_count: got %0d required 2", got_id.size());
        end else begin
            vec++;
            if (got_id[0] !== 4'd1 || got_data[0] !== 16'h00E1 ||
                got_id[1] !== 4'd2 || got_data[1] !== 16'h00E2) begin
                miss++;
                $display("FAIL timeout_order: got %0d:%h %0d:%h required 1:00e1 2:00e2",
                         got_id[0], got_data[0], got_id[1], got_data[1]);
            end
        end
`else
        vec++;
        if (skip_t != -1 || got_id.size() != 0 || occupancy !== 5'd2) begin
            miss++;
            $display("FAIL no_timeout: got skip_cycle=%0d outputs=%0d occ=%0d required -1 0 2",
                     skip_t, got_id.size(), occupancy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_out_of_order();
        test_backpressure();
        test_overflow();
        test_wrap_reset();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/linear_result_reorder.md
LINEAR_RESULT_REORDER -- requirements
Module: linear_result_reorder

Interface
REQ-001 Parameter DW, default 16, result width; must match the linear-function y width.
REQ-002 Parameter IDW, default 4, tag width; buffer depth is 2**IDW (16).
REQ-003 Parameter TIMEOUT, default 64, head-wait limit in cycles; used only with REORDER_TIMEOUT_EN.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 sysrst  input  1  reset, asynchronous, active-high.
REQ-006 rvalid  input  1  result strobe from the linear-function stage; no backpressure exists upstream.
REQ-007 y  input  DW  fixed-point result; sampled when rvalid=1.
REQ-008 oid  input  IDW  result tag; sampled when rvalid=1.
REQ-009 dout_valid  output  1  in-order result available.
REQ-010 dout_ready  input  1  consumer accepts the result.
REQ-011 dout_data  output  DW  in-order result.
REQ-012 dout_id  output  IDW  tag of dout_data.
REQ-013 occupancy  output  IDW+1  number of buffered entries, excluding the output register.
REQ-014 err_overflow  output  1  sticky; set when a result arrives for a slot that is already occupied.
REQ-015 err_skip  output  1  sticky; set when a head slot is skipped by timeout (tied 0 without the macro).

Function
REQ-016 The block has a 16-slot buffer indexed by oid. Each slot holds a valid bit and DW data bits.
REQ-017 When rvalid=1 and slot[oid] is empty, the block writes y and sets valid at that edge.
REQ-018 When rvalid=1 and slot[oid] is occupied, the block drops the new data, keeps the old data, and sets err_overflow.
REQ-019 The head pointer starts at 0 and releases tags strictly in order 0,1,...,15,0. It wraps from 15 to 0 with no gap.
REQ-020 The output register loads slot[head] when slot[head] is valid and either dout_valid=0 or dout_valid&dout_ready=1. On that load, slot[head] is cleared and head increments.
REQ-021 Latency: a result for the current head with rvalid at cycle N gives dout_valid=1 in cycle N+2. The rate is one result per cycle when dout_ready is held at 1.
REQ-022 While dout_valid=1 and dout_ready=0, dout_data and dout_id stay stable and no further head load occurs.
REQ-023 A write and a head read of different slots in the same cycle both take effect. occupancy changes by +1-1=0.
REQ-024 A write to slot[head] in the same cycle that the head slot is empty is seen at the next cycle. It is never bypassed.
REQ-025 occupancy = count of set valid bits. Its range is 0..16; it never wraps.

Reset
REQ-026 While sysrst=1, asynchronously:
- all slot valid bits = 0
- head = 0
- dout_valid = 0
- dout_data = 0
- dout_id = 0
- occupancy = 0
- err_overflow = 0
- err_skip = 0
- timeout counter = 0
REQ-027 Reset asserted mid-operation discards all buffered and in-flight results. No output is produced for them after release.
REQ-028 After sysrst deasserts, the first edge may accept rvalid.

Configuration
REQ-029 Macro REORDER_TIMEOUT_EN, when defined: a counter increments each cycle that slot[head] is empty and occupancy>0.
- The counter clears on any head load, and also when occupancy=0.
- When the count reaches TIMEOUT, head increments without output, err_skip is set, and the counter clears.
REQ-030 Macro undefined: no counter logic exists, err_skip is constant 0, and the head waits indefinitely.

Structure
REQ-031 Shared package linear_pkg holds the constants LIN_DW=16, LIN_IDW=4, LIN_DEPTH=16 and the slot struct type (valid, data). The linear-function stage uses the same package.
REQ-032 One sub-module, reorder_timer, contains the timeout counter. It is instantiated only under REORDER_TIMEOUT_EN.

Verification
REQ-033 In-order: tags 0..7 on consecutive cycles with y=0x0036..0x003D and dout_ready=1 -> dout ids 0..7 on consecutive cycles, first dout_valid 2 cycles after tag 0, data matches.
REQ-034 Out-of-order: tags 2,0,1 with y=0x00A2,0x00A0,0x00A1 -> output order 0,1,2 with data 0x00A0,0x00A1,0x00A2; occupancy peaks at 2.
REQ-035 Backpressure: tags 0..3, dout_ready=0 for 5 cycles then 1 -> dout_id=0 is held stable for 5 cycles, then ids 1..3 follow; no data is lost.
REQ-036 Overflow: tag 5 sent twice (0x1111 then 0x2222) with head stuck at 0 -> err_overflow=1, slot 5 holds 0x1111, occupancy=1.
REQ-037 Wrap and reset: 20 tags 0..15,0..3 -> 20 ordered outputs across the wrap. Then sysrst pulsed while tags 4,6 are pending -> all outputs and occupancy are 0 during reset, and nothing is emitted after release.
REQ-038 Timeout (macro defined, TIMEOUT=64): tags 1 and 2 sent, tag 0 never -> after 64 cycles err_skip=1, then ids 1,2 are emitted. Macro undefined: no output and err_skip stays 0.
